row_merge: RTL and testbench
============================

// Module: row_merge
// PURPOSE
//  Sequential 2048 slide/merge engine for one row or column of four tiles.
//  It feeds the board-update stage: per move, the game controller permutes the
//  row in move direction (index 0 = destination edge), pulses start, and
//  consumes out0..out3 plus moved/score_add when done pulses.
//  Tiles are exponents: 0 = empty, e = value 2^e.
// PARAMETERS
//  TW  4   tile exponent width; max exponent EMAX = 2^TW-1
//  SW  18  score_add width; must hold 2*2^EMAX
// PORTS
//  clk        in   1   system clock, rising edge
//  clr        in   1   synchronous active-high reset
//  start      in   1   request; accepted only in IDLE
//  num1..num4 in   TW  input tiles, index 0..3; sampled at the start edge only
//  busy       out  1   1 while state != IDLE
//  done       out  1   one-cycle pulse; results valid
//  out1..out4 out  TW  merged row, packed toward index 0, zero-filled
//  moved      out  1   1 if merged row != captured input row
//  score_add  out  SW  sum of 2^(new exponent) over merges this pass
// BEHAVIOUR
//  Reset (clr=1 at an edge): state=IDLE; busy=0, done=0, out*=0, moved=0,
//   score_add=0; all internal regs cleared. clr has priority over start.
//  States: IDLE -> SCAN (4 cycles, idx 0..3) -> FLUSH -> DONE -> IDLE.
//  IDLE: start=1 captures num1..4 into in_r, clears wp, pend_v, acc,
//   idx=0, res=0; next state SCAN. start=0 stays IDLE.
//  SCAN, per cycle, t = in_r[idx]:
//   t==0: skip.
//   pend_v && pend==t && t!=EMAX: res[wp]=t+1; wp++; pend_v=0;
//    acc += 1<<(t+1).
//   pend_v otherwise: res[wp]=pend; wp++; pend=t (pend_v stays 1).
//   !pend_v: pend=t; pend_v=1.
//   idx==3 -> FLUSH, else idx++.
//  FLUSH: if pend_v, res[wp]=pend. Register out*=res, score_add=acc,
//   moved=(res!=in_r); next state DONE.
//  DONE: done=1 (Moore output) for exactly one cycle; next IDLE.
//  Latency: start sampled at edge k -> done high between edges k+5 and k+6;
//   out*/moved/score_add change only at edge k+5 and hold until the next
//   pass's FLUSH or clr.
//  start while busy (SCAN/FLUSH/DONE) is ignored, not queued.
//  Each tile merges at most once per pass; merges resolve from index 0
//   ([2,2,2,0] -> [3,2,0,0]).
//  EMAX tiles never merge (saturation); no exponent overflow possible.
//  wp never exceeds 3: writes <= nonzero tiles <= 4.
//  Score width: acc max 2*2^EMAX fits in SW; no wrap at defaults.
//  clr mid-pass: abort immediately; no done; outputs return to 0.
// TESTING
//  1 [1,1,1,1] start -> done 6 cycles later; out=[2,2,0,0], score_add=8, moved=1
//  2 [0,2,0,2] -> out=[3,0,0,0], score_add=8, moved=1; [2,2,2,0] -> [3,2,0,0], 8
//  3 [1,2,3,4] -> out=[1,2,3,4], score_add=0, moved=0; [0,0,0,0] -> all 0, moved=0
//  4 [15,15,0,0] (TW=4) -> out=[15,15,0,0], score_add=0, moved=0 (no merge)
//  5 start held high for 10 cycles -> exactly one done per pass; busy=1
//    for cycles 1..6 after acceptance; mid-pass start has no effect on results
//  6 clr at 2nd SCAN cycle -> next cycle busy=0, out*=0, score_add=0;
//    no done pulse; then [3,0,3,1] -> [4,1,0,0], score_add=16

Source files
------------

// File: rtl/row_merge.sv
// ---------------------------------------------------------------------------
// row_merge
//   Sequential 2048 slide/merge engine for one row (or column) of four tiles.
//   The caller permutes the row so index 0 is the destination edge, pulses
//   start, and takes out1..out4 / moved / score_add when done pulses.
//   Tiles are exponents: 0 = empty, e = value 2^e.
//
//   Pass timing: start accepted at edge k -> SCAN at edges k+1..k+4 (one
//   tile per cycle) -> FLUSH registers the results at edge k+5 -> DONE
//   (done=1 for one cycle) -> IDLE at edge k+6.
//
// Ports
//   clk            system clock, rising edge
//   clr            synchronous active-high reset, priority over start
//   start          pass request, accepted only in IDLE
//   num1..num4     input tiles for index 0..3, sampled at the accepting edge
//   busy           1 while a pass is in progress (state != IDLE)
//   done           one-cycle pulse, results valid
//   out1..out4     merged row, packed toward index 0, zero-filled
//   moved          1 if the merged row differs from the captured row
//   score_add      sum of 2^(new exponent) over all merges of the pass
// ---------------------------------------------------------------------------
module row_merge #(
    parameter int TW = 4,
    parameter int SW = 18
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [TW-1:0] num1,
    input  logic [TW-1:0] num2,
    input  logic [TW-1:0] num3,
    input  logic [TW-1:0] num4,
    output logic          busy,
    output logic          done,
    output logic [TW-1:0] out1,
    output logic [TW-1:0] out2,
    output logic [TW-1:0] out3,
    output logic [TW-1:0] out4,
    output logic          moved,
    output logic [SW-1:0] score_add
);

    // Largest exponent; such tiles saturate and never merge.
    localparam logic [TW-1:0] EMAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [3:0][TW-1:0] in_r;     // captured input row
    logic [3:0][TW-1:0] res;      // merged row being built
    logic [3:0][TW-1:0] res_fin;  // res with the pending tile placed
    logic [1:0]         idx;      // tile being scanned
    logic [1:0]         wp;       // next write slot in res
    logic [TW-1:0]      pend;     // tile waiting for a possible partner
    logic               pend_v;
    logic [SW-1:0]      acc;      // score accumulated this pass
    logic [TW-1:0]      t;        // current tile

    assign t    = in_r[idx];
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // ---------------- state register ----------------
    // NOTE: sequential state is updated with non-blocking (<=) assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every always_comb output gets a default first; a path that leaves
    // it unassigned would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (idx == 2'd3) state_nx = FLUSH;
            FLUSH:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The still-pending tile becomes the final entry; wp is at most 3 here
    // because a row holds at most four nonzero tiles.
    always_comb begin
        res_fin = res;
        if (pend_v) res_fin[wp] = pend;
    end

    // ---------------- datapath ----------------
    // NOTE: the small row registers (in_r, res) are flip-flops, not a RAM, so
    // they are cleared on clr together with the rest of the state.
    always_ff @(posedge clk) begin
        if (clr) begin
            in_r      <= '0;
            res       <= '0;
            idx       <= '0;
            wp        <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            acc       <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out4      <= '0;
            moved     <= 1'b0;
            score_add <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        in_r   <= {num4, num3, num2, num1};
                        res    <= '0;
                        idx    <= '0;
                        wp     <= '0;
                        pend   <= '0;
                        pend_v <= 1'b0;
                        acc    <= '0;
                    end
                end
                SCAN: begin
                    if (t != '0) begin
                        if (pend_v && (pend == t) && (t != EMAX)) begin
                            // Merge: the pair is consumed, so the next tile
                            // starts a fresh pending slot (one merge per tile).
                            res[wp] <= t + 1'b1;
                            wp      <= wp + 2'd1;
                            pend_v  <= 1'b0;
                            acc     <= acc + (SW'(1) << ({1'b0, t} + 1'b1));
                        end else if (pend_v) begin
                            res[wp] <= pend;
                            wp      <= wp + 2'd1;
                            pend    <= t;
                        end else begin
                            pend    <= t;
                            pend_v  <= 1'b1;
                        end
                    end
                    idx <= idx + 2'd1;
                end
                FLUSH: begin
                    out1      <= res_fin[0];
                    out2      <= res_fin[1];
                    out3      <= res_fin[2];
                    out4      <= res_fin[3];
                    score_add <= acc;
                    moved     <= (res_fin != in_r);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_row_merge.sv
// ---------------------------------------------------------------------------
// tb_row_merge
//   Self-checking bench for row_merge. Stimulus pushes the reference result
//   of each accepted pass into a scoreboard queue; an independent monitor pops
//   and compares whenever done is seen. The reference model works on a list
//   of nonzero tiles and merges neighbouring equal pairs from the front.
// ---------------------------------------------------------------------------
module tb_row_merge;

    localparam int TW   = 4;
    localparam int SW   = 18;
    localparam int EMAX = 15;

    typedef logic [3:0][TW-1:0] row_t;

    typedef struct packed {
        row_t          o;
        logic          moved;
        logic [SW-1:0] score;
    } exp_t;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [TW-1:0] num1, num2, num3, num4;
    logic          busy, done;
    logic [TW-1:0] out1, out2, out3, out4;
    logic          moved;
    logic [SW-1:0] score_add;

    int   checks   = 0;
    int   errors   = 0;
    int   pushes   = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t last_exp;

    row_merge #(.TW(TW), .SW(SW)) dut (
        .clk(clk), .clr(clr), .start(start),
        .num1(num1), .num2(num2), .num3(num3), .num4(num4),
        .busy(busy), .done(done),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .moved(moved), .score_add(score_add)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic row_t mk(input int t0, input int t1, input int t2, input int t3);
        row_t r;
        r[0] = TW'(t0);
        r[1] = TW'(t1);
        r[2] = TW'(t2);
        r[3] = TW'(t3);
        return r;
    endfunction

    // Reference: compact nonzero tiles, then merge equal neighbours front to
    // back, each tile at most once, saturated tiles never merging.
    function automatic exp_t model(input row_t row);
        exp_t e;
        int   q[$];
        int   o[4];
        int   n;
        int   i;
        int   score;
        for (int k = 0; k < 4; k++) begin
            o[k] = 0;
            if (row[k] != 0) q.push_back(int'(row[k]));
        end
        n = 0;
        i = 0;
        score = 0;
        while (i < q.size()) begin
            if (i + 1 < q.size() && q[i] == q[i+1] && q[i] != EMAX) begin
                o[n] = q[i] + 1;
                score += 1 << (q[i] + 1);
                i += 2;
            end else begin
                o[n] = q[i];
                i += 1;
            end
            n++;
        end
        for (int k = 0; k < 4; k++) e.o[k] = TW'(o[k]);
        e.score = SW'(score);
        e.moved = (e.o != row);
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_row", 64'({out4, out3, out2, out1}), 64'(e.o));
                    check("moved", 64'(moved), 64'(e.moved));
                    check("score_add", 64'(score_add), 64'(e.score));
                end
            end
        end
    end

    task automatic drive_row(input row_t r);
        num1 = r[0];
        num2 = r[1];
        num3 = r[2];
        num4 = r[3];
    endtask

    // One full pass with latency and hold checks; DUT is idle on entry.
    task automatic do_pass(input row_t r);
        int n;
        @(negedge clk);
        check("hold_out", 64'({out4, out3, out2, out1}), 64'(last_exp.o));
        check("hold_score", 64'(score_add), 64'(last_exp.score));
        drive_row(r);
        start = 1'b1;
        @(posedge clk);
        last_exp = model(r);
        sb.push_back(last_exp);
        pushes++;
        #1 start = 1'b0;
        drive_row(~r);  // later input changes must not affect the pass
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_latency", 64'(n), 64'd5);
        @(posedge clk);
        #1;
        check("idle_after_done", 64'({busy, done}), 64'd0);
    endtask

    initial begin
        row_t r, a, b;
        int   d0;

        clr = 1'b1;
        start = 1'b0;
        drive_row('0);
        last_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({busy, done, moved, out4, out3, out2, out1, score_add}), 64'd0);
        clr = 1'b0;

        // Directed rows.
        do_pass(mk(1, 1, 1, 1));
        do_pass(mk(0, 2, 0, 2));
        do_pass(mk(2, 2, 2, 0));
        do_pass(mk(1, 2, 3, 4));
        do_pass(mk(0, 0, 0, 0));
        do_pass(mk(15, 15, 0, 0));
        do_pass(mk(14, 14, 15, 15));
        do_pass(mk(0, 0, 0, 7));

        // Randomized rows: mostly small exponents for frequent merges, some
        // near the saturation limit.
        for (int p = 0; p < 40; p++) begin
            for (int k = 0; k < 4; k++) begin
                if (p % 4 == 3) r[k] = TW'($urandom_range(13, 15));
                else            r[k] = TW'($urandom_range(0, 4));
                if ($urandom_range(0, 4) == 0) r[k] = '0;
            end
            do_pass(r);
        end

        // start held high for 10 edges: accepted at edge 0 and again at
        // edge 7 (first IDLE edge after DONE); inputs change after edge 0.
        a = mk(3, 3, 1, 1);
        b = mk(0, 5, 5, 5);
        @(negedge clk);
        drive_row(a);
        start = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            if (j == 0) begin
                sb.push_back(model(a));
                pushes++;
            end
            if (j == 7) begin
                last_exp = model(b);
                sb.push_back(last_exp);
                pushes++;
            end
            #1;
            if (j == 0) drive_row(b);
            check($sformatf("busy_held_%0d", j), 64'(busy), 64'((j < 6) || (j >= 7)));
        end
        start = 1'b0;
        for (int j = 0; j < 20 && busy !== 1'b0; j++) @(posedge clk);
        #1;
        check("held_start_idle", 64'(busy), 64'd0);
        check("held_start_dones", 64'(done_cnt), 64'(pushes));

        // clr during the second SCAN cycle aborts the pass with no done.
        @(negedge clk);
        drive_row(mk(5, 5, 6, 7));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check("abort_clear", 64'({busy, done, moved, out4, out3, out2, out1, score_add}), 64'd0);
        d0 = done_cnt;
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'(d0));
        last_exp = '0;
        do_pass(mk(3, 0, 3, 1));

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("done_total", 64'(done_cnt), 64'(pushes));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
